// File: rtl/reflet_float_to_int_seq.sv
// Multi-cycle float-to-integer converter with valid/ready handshakes, four rounding modes,
// saturation and invalid/inexact flags. Right-alignment is done a few bits per cycle.
module reflet_float_to_int_seq #(
    parameter int int_size   = 16,
    parameter int float_size = 32,
    parameter bit is_signed  = 1'b1,
    parameter int shift_step = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [float_size-1:0] float_in,
    input  logic [1:0]            round_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [int_size-1:0]   int_out,
    output logic                  flag_inv,
    output logic                  flag_inx,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int EXP_W  = (float_size == 16) ? 5 : (float_size == 64) ? 11 : 8;
    localparam int FRAC_W = float_size - 1 - EXP_W;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int MAG_W  = ((int_size > FRAC_W + 1) ? int_size : FRAC_W + 1) + 1;
    localparam int CNT_W  = $clog2(FRAC_W + 3);

    localparam logic [CNT_W-1:0] STEP = CNT_W'(shift_step);
    localparam logic [MAG_W-1:0] POS_LIM = is_signed ? (MAG_W'(1) << (int_size - 1)) - MAG_W'(1)
                                                     : (MAG_W'(1) << int_size) - MAG_W'(1);
    localparam logic [MAG_W-1:0] NEG_LIM = is_signed ? (MAG_W'(1) << (int_size - 1))
                                                     : {MAG_W{1'b0}};
    localparam logic [int_size-1:0] INT_MAX = is_signed ? {1'b0, {(int_size-1){1'b1}}}
                                                        : {int_size{1'b1}};
    localparam logic [int_size-1:0] INT_MIN = is_signed ? {1'b1, {(int_size-1){1'b0}}}
                                                        : {int_size{1'b0}};

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_SHIFT, S_ROUND, S_DONE} state_t;
    typedef enum logic [1:0] {RM_RNE, RM_RZ, RM_UP, RM_DOWN} round_t;

    state_t                state;
    round_t                mode_q;
    logic [float_size-1:0] op_q;
    logic [MAG_W-1:0]      mag_q;
    logic [CNT_W-1:0]      s_q;
    logic                  r_q;
    logic                  sticky_q;
    logic                  big_q;

    logic                  sign;
    logic [EXP_W-1:0]      exp_f;
    logic [FRAC_W-1:0]     mant_f;

    assign sign   = op_q[float_size-1];
    assign exp_f  = op_q[float_size-2 -: EXP_W];
    assign mant_f = op_q[FRAC_W-1:0];

    assign in_ready = (state == S_IDLE) && reset;

    int                  e_val;
    int                  s_full;
    logic [CNT_W-1:0]    s_init;
    logic [MAG_W-1:0]    mag_lsh;
    logic [CNT_W-1:0]    k;
    logic [MAG_W-1:0]    bit_mask;
    logic [MAG_W-1:0]    mag_shr;
    logic                r_shr;
    logic                sticky_shr;
    logic                inc;
    logic [MAG_W-1:0]    mag_rnd;
    logic                ovf;
    logic [int_size-1:0] mag_lo;
    logic [int_size-1:0] res_rnd;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        e_val   = int'(exp_f) - BIAS;
        s_full  = FRAC_W - e_val;
        s_init  = (s_full > FRAC_W + 2) ? CNT_W'(FRAC_W + 2) : CNT_W'(s_full);
        mag_lsh = MAG_W'({1'b1, mant_f}) << (e_val - FRAC_W);

        // Round bit is the last bit shifted out; everything below it (and the old round bit) is sticky.
        k          = (s_q > STEP) ? STEP : s_q;
        bit_mask   = MAG_W'(1) << (k - 1'b1);
        mag_shr    = mag_q >> k;
        r_shr      = |(mag_q & bit_mask);
        sticky_shr = sticky_q | r_q | (|(mag_q & (bit_mask - MAG_W'(1))));

        inc = 1'b0;
        case (mode_q)
            RM_RNE:  inc = r_q & (sticky_q | mag_q[0]);
            RM_RZ:   inc = 1'b0;
            RM_UP:   inc = (r_q | sticky_q) & ~sign;
            default: inc = (r_q | sticky_q) & sign;
        endcase
        mag_rnd = mag_q + MAG_W'(inc);
        // For unsigned outputs NEG_LIM is zero, so any nonzero negative result saturates to 0.
        ovf     = big_q | (sign ? (mag_rnd > NEG_LIM) : (mag_rnd > POS_LIM));
        mag_lo  = mag_rnd[int_size-1:0];
        res_rnd = sign ? -mag_lo : mag_lo;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            mode_q    <= RM_RNE;
            op_q      <= '0;
            mag_q     <= '0;
            s_q       <= '0;
            r_q       <= 1'b0;
            sticky_q  <= 1'b0;
            big_q     <= 1'b0;
            int_out   <= '0;
            flag_inv  <= 1'b0;
            flag_inx  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= float_in;
                        mode_q <= round_t'(round_mode);
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_q      <= 1'b0;
                    sticky_q <= 1'b0;
                    big_q    <= (e_val >= int_size);
                    if (exp_f == '1) begin
                        int_out   <= (mant_f != '0 || !sign) ? INT_MAX : INT_MIN;
                        flag_inv  <= 1'b1;
                        flag_inx  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (exp_f == '0) begin
                        if (mant_f == '0) begin
                            int_out   <= '0;
                            flag_inv  <= 1'b0;
                            flag_inx  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            // Subnormals are far below 1: only the sticky bit survives.
                            mag_q    <= '0;
                            sticky_q <= 1'b1;
                            state    <= S_ROUND;
                        end
                    end else if (e_val >= FRAC_W) begin
                        mag_q <= mag_lsh;
                        state <= S_ROUND;
                    end else begin
                        mag_q <= MAG_W'({1'b1, mant_f});
                        s_q   <= s_init;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    mag_q    <= mag_shr;
                    r_q      <= r_shr;
                    sticky_q <= sticky_shr;
                    s_q      <= s_q - k;
                    if (s_q == k) state <= S_ROUND;
                end
                S_ROUND: begin
                    if (ovf) begin
                        int_out  <= sign ? INT_MIN : INT_MAX;
                        flag_inv <= 1'b1;
                        flag_inx <= 1'b0;
                    end else begin
                        int_out  <= res_rnd;
                        flag_inv <= 1'b0;
                        flag_inx <= r_q | sticky_q;
                    end
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_float_to_int_seq.sv
// Directed bench: a signed and an unsigned 16-bit converter from 32-bit floats, with
// hand-computed results, flags and latencies.
module tb_reflet_float_to_int_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] fs = '0, fu = '0;
    logic [1:0]  ms = '0, mu = '0;
    logic        vs = 1'b0, vu = 1'b0;
    logic        ors = 1'b0, oru = 1'b0;
    logic        irs, iru;
    logic [15:0] ios, iou;
    logic        invs, invu, inxs, inxu, ovs, ovu;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reflet_float_to_int_seq #(.int_size(16), .float_size(32), .is_signed(1'b1), .shift_step(4)) dut_s (
        .clk(clk), .reset(rst), .float_in(fs), .round_mode(ms), .in_valid(vs), .in_ready(irs),
        .int_out(ios), .flag_inv(invs), .flag_inx(inxs), .out_valid(ovs), .out_ready(ors)
    );

    reflet_float_to_int_seq #(.int_size(16), .float_size(32), .is_signed(1'b0), .shift_step(4)) dut_u (
        .clk(clk), .reset(rst), .float_in(fu), .round_mode(mu), .in_valid(vu), .in_ready(iru),
        .int_out(iou), .flag_inv(invu), .flag_inx(inxu), .out_valid(ovu), .out_ready(oru)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, wait (bounded) for out_valid, check, then drain.
    task automatic run_op(input string tag, input bit u, input logic [31:0] f, input logic [1:0] m,
                          input logic [15:0] e_int, input logic e_inv, input logic e_inx,
                          input int e_lat);
        int lat;
        @(negedge clk);
        check({tag, "_ready"}, u ? iru : irs, 32'd1);
        if (u) begin fu = f; mu = m; vu = 1'b1; end
        else   begin fs = f; ms = m; vs = 1'b1; end
        @(posedge clk); #1;
        vu = 1'b0;
        vs = 1'b0;
        lat = 0;
        while (!(u ? ovu : ovs) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_valid"}, u ? ovu : ovs, 32'd1);
        check({tag, "_int"},   u ? iou : ios, 32'(e_int));
        check({tag, "_inv"},   u ? invu : invs, 32'(e_inv));
        check({tag, "_inx"},   u ? inxu : inxs, 32'(e_inx));
        if (e_lat > 0) check({tag, "_lat"}, lat, e_lat);
        @(negedge clk);
        if (u) oru = 1'b1; else ors = 1'b1;
        @(posedge clk); #1;
        oru = 1'b0;
        ors = 1'b0;
    endtask

    initial begin
        int lat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", ovs, 32'd0);
        check("rst_int",   ios, 32'd0);
        check("rst_inv",   invs, 32'd0);
        check("rst_inx",   inxs, 32'd0);
        check("rst_ready", irs, 32'd0);
        rst = 1'b1;
        #1;
        check("idle_ready_s", irs, 32'd1);
        check("idle_ready_u", iru, 32'd1);

        // Signed conversions
        run_op("p1_5_rne",  1'b0, 32'h3FC00000, 2'd0, 16'h0002, 1'b0, 1'b1, 8);
        run_op("p2_5_rne",  1'b0, 32'h40200000, 2'd0, 16'h0002, 1'b0, 1'b1, 8);
        run_op("n2_5_rz",   1'b0, 32'hC0200000, 2'd1, 16'hFFFE, 1'b0, 1'b1, 8);
        run_op("n2_5_up",   1'b0, 32'hC0200000, 2'd2, 16'hFFFE, 1'b0, 1'b1, 8);
        run_op("n2_5_dn",   1'b0, 32'hC0200000, 2'd3, 16'hFFFD, 1'b0, 1'b1, 8);
        run_op("n32768",    1'b0, 32'hC7000000, 2'd0, 16'h8000, 1'b0, 1'b0, 4);
        run_op("p32768",    1'b0, 32'h47000000, 2'd0, 16'h7FFF, 1'b1, 1'b0, 4);
        run_op("p1e10",     1'b0, 32'h501502F9, 2'd0, 16'h7FFF, 1'b1, 1'b0, 2);
        run_op("nan",       1'b0, 32'h7FC00000, 2'd0, 16'h7FFF, 1'b1, 1'b0, 1);
        run_op("ninf",      1'b0, 32'hFF800000, 2'd0, 16'h8000, 1'b1, 1'b0, 1);
        run_op("p0_5_rne",  1'b0, 32'h3F000000, 2'd0, 16'h0000, 1'b0, 1'b1, 8);
        run_op("p0_25_up",  1'b0, 32'h3E800000, 2'd2, 16'h0001, 1'b0, 1'b1, 9);
        run_op("n0_25_rne", 1'b0, 32'hBE800000, 2'd0, 16'h0000, 1'b0, 1'b1, 9);
        run_op("sub_up",    1'b0, 32'h00000001, 2'd2, 16'h0001, 1'b0, 1'b1, 2);

        // Unsigned conversions
        run_op("u_n0_75_rne", 1'b1, 32'hBF400000, 2'd0, 16'h0000, 1'b1, 1'b0, 8);
        run_op("u_n0_75_rz",  1'b1, 32'hBF400000, 2'd1, 16'h0000, 1'b0, 1'b1, 8);
        run_op("u_max",       1'b1, 32'h477FFF00, 2'd0, 16'hFFFF, 1'b0, 1'b0, 4);
        run_op("u_nzero",     1'b1, 32'h80000000, 2'd0, 16'h0000, 1'b0, 1'b0, 0);
        run_op("u_nan",       1'b1, 32'h7FC00000, 2'd0, 16'hFFFF, 1'b1, 1'b0, 1);

        // Backpressure: hold out_ready low in DONE while a second operand waits
        @(negedge clk);
        fs = 32'h3FC00000; ms = 2'd0; vs = 1'b1;
        @(posedge clk); #1;
        vs = 1'b0;
        lat = 0;
        while (!ovs && lat < 40) begin @(posedge clk); #1; lat++; end
        check("bp_valid", ovs, 32'd1);
        fs = 32'h40400000;
        vs = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", ovs, 32'd1);
            check("bp_hold_int",   ios, 32'h0002);
            check("bp_hold_inx",   inxs, 32'd1);
            check("bp_hold_ready", irs, 32'd0);
        end
        ors = 1'b1;
        @(posedge clk); #1;
        ors = 1'b0;
        check("bp_release_valid", ovs, 32'd0);
        check("bp_release_ready", irs, 32'd1);
        @(posedge clk); #1;
        vs = 1'b0;
        check("bp_second_busy", irs, 32'd0);
        lat = 0;
        while (!ovs && lat < 40) begin @(posedge clk); #1; lat++; end
        check("bp_second_valid", ovs, 32'd1);
        check("bp_second_int",   ios, 32'h0003);
        check("bp_second_inx",   inxs, 32'd0);
        check("bp_second_lat",   lat, 32'd8);
        @(negedge clk);
        ors = 1'b1;
        @(posedge clk); #1;
        ors = 1'b0;

        // Reset while shifting drops the operation and clears the result
        @(negedge clk);
        fs = 32'h40200000; ms = 2'd0; vs = 1'b1;
        @(posedge clk); #1;
        vs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", ovs, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", ovs, 32'd0);
        check("mid_rst_int",   ios, 32'd0);
        check("mid_rst_ready", irs, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_idle", irs, 32'd1);
        run_op("post_rst", 1'b0, 32'hC0200000, 2'd0, 16'hFFFE, 1'b0, 1'b1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
